nexys_starship_random_gen: RTL

NEXYS_STARSHIP_RANDOM_GEN -- requirements
Module: nexys_starship_random_gen

---
 rtl/nexys_starship_random_gen.sv | 51 +++++
 1 files changed

// File: rtl/nexys_starship_random_gen.sv
// nexys_starship_random_gen: LFSR-driven ship-part break events and repair-stage timer clock
module nexys_starship_random_gen #(
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [15:0] BREAK_PERIOD = 16'd50000,
  parameter logic [25:0] TIMER_HALF   = 26'd25000000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       play_flag,
  input  logic       gameover_ctrl,
  output logic [3:0] random_hex,
  output logic       LR_random,
  output logic       RR_random,
  output logic       UR_random,
  output logic       DR_random,
  output logic       timer_clk
);
  localparam logic [2:0] IDLE = 3'b001;
  localparam logic [2:0] RUN  = 3'b010;
  localparam logic [2:0] HALT = 3'b100;
  logic [2:0]  state, state_nxt;
  logic [15:0] lfsr, cnt;
  logic [25:0] pre;
  logic        tc, wrap, brk;
  assign tc   = cnt == BREAK_PERIOD - 16'd1;
  assign wrap = pre == TIMER_HALF - 26'd1;
  // gameover on a terminal count suppresses the event entirely
  assign brk  = state == RUN && tc && !gameover_ctrl;
  always_comb
    state_nxt = (state == IDLE) ? ((play_flag && !gameover_ctrl) ? RUN : IDLE) :
                (state == RUN)  ? (gameover_ctrl ? HALT : RUN) :
                (state == HALT) ? ((!play_flag && !gameover_ctrl) ? IDLE : HALT) : IDLE;
  always_ff @(posedge Clk or negedge Reset)
    if (!Reset) begin
      state      <= IDLE;
      lfsr       <= LFSR_SEED;
      cnt        <= '0;
      pre        <= '0;
      timer_clk  <= 1'b0;
      random_hex <= 4'h0;
      {DR_random, UR_random, RR_random, LR_random} <= 4'b0;
    end else begin
      state     <= state_nxt;
      lfsr      <= (lfsr == '0) ? LFSR_SEED : {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      cnt       <= (state != RUN || tc) ? 16'd0 : cnt + 16'd1;
      pre       <= wrap ? 26'd0 : pre + 26'd1;
      timer_clk <= timer_clk ^ wrap;
      {DR_random, UR_random, RR_random, LR_random} <= brk ? 4'b0001 << lfsr[5:4] : 4'b0000;
      if (brk) random_hex <= (lfsr[3:0] == 4'h0) ? 4'hF : lfsr[3:0];
    end
endmodule
